disp_mux_ctrl: RTL and testbench
================================

DISP_MUX_CTRL -- requirements
Module: disp_mux_ctrl

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of multiplexed digits.
REQ-002 SHALL have parameter SLOT_CYC, default 50000, clock cycles per digit slot; must be at least BLANK_CYC+1.
REQ-003 SHALL have parameter BLANK_CYC, default 500, anti-ghosting blank cycles at the start of each slot; must be at least 1.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port ld_valid, input, 1, load request.
REQ-007 SHALL have port ld_ready, output, 1, load can be accepted.
REQ-008 SHALL have port ld_hex, input, 4*N_DIGITS, hex nibbles; nibble 0 is the rightmost digit.
REQ-009 SHALL have port ld_dp, input, N_DIGITS, decimal point per digit, active high.
REQ-010 SHALL have port lz_en, input, 1, leading-zero suppression enable, sampled live.
REQ-011 SHALL have port an, output, N_DIGITS, digit anodes, active low.
REQ-012 SHALL have port sseg, output, 8, segments, active low; bit 7 is dp and bits 6:0 are a..g.
REQ-013 SHALL have port frame_tick, output, 1, one-cycle pulse at each frame boundary.

Function
REQ-014 A load SHALL be accepted when ld_valid and ld_ready are both high; ld_hex and ld_dp are then captured into the pending registers.
REQ-015 ld_ready SHALL deassert on the cycle after an accepted load and reassert on the cycle after the commit.
REQ-016 Commit SHALL copy pending into the active registers on the cycle frame_tick is high; there is no tearing within a frame.
REQ-017 A load accepted on the same cycle as frame_tick SHALL NOT be committed by that frame_tick; it commits at the next one.
REQ-018 The slot state machine SHALL have states BLANK and ON.
- BLANK lasts BLANK_CYC cycles, then goes to ON.
- ON lasts SLOT_CYC-BLANK_CYC cycles, then goes to BLANK and increments the digit index.
REQ-019 The digit index SHALL count 0..N_DIGITS-1 and wrap to 0.
- frame_tick is high for exactly one cycle: the last ON cycle of digit N_DIGITS-1.
REQ-020 In BLANK, an SHALL be all ones and sseg SHALL be 8'hFF.
REQ-021 In ON with index i:
- an has bit i at 0 and all other bits at 1.
- sseg[6:0] is the decoded nibble i.
- sseg[7] is the inverse of dp bit i.
REQ-022 Decode SHALL use the standard active-low 0-F glyphs; for example 0 -> 7'b0000001, 8 -> 7'b0000000, F -> 7'b0111000.
REQ-023 With lz_en high, digit i>0 SHALL be suppressed when it and all higher digits are zero.
- A suppressed digit drives sseg[6:0] to 7'h7F; its dp and anode behave normally.
- Digit 0 is never suppressed.
REQ-024 an and sseg SHALL be registered, lagging the state and index by exactly one cycle.
REQ-025 Slot and cycle counters SHALL be sized with the ceiling log2 of their limits and SHALL wrap without overflow.

Reset
REQ-026 On rst_n low at a clock edge the block SHALL force:
- state to BLANK, index 0, counters 0;
- active and pending registers to 0;
- an all ones, sseg 8'hFF;
- ld_ready 1, frame_tick 0.
REQ-027 Reset asserted mid-slot or with a load pending SHALL discard the pending data; the first slot after release is digit 0 BLANK.

Structure
REQ-028 A shared package disp_pkg SHALL hold:
- the slot state enum;
- the SSEG_OFF constant 8'hFF;
- the glyph constants.
REQ-029 Decoding SHALL be a combinational sub-module sseg_decoder (4-bit hex in, 7-bit active-low out), instantiated once and fed by the index-selected nibble.

Verification
All scenarios use N_DIGITS=4, SLOT_CYC=8, BLANK_CYC=2.
REQ-030 Reset, then idle for 40 cycles:
- an shows 1111 for 2 cycles, then 1110 for 6; then 1111 for 2 and 1101 for 6; and so on through the digits.
- frame_tick pulses every 32 cycles.
REQ-031 Load ld_hex=16'h12AF, ld_dp=4'b0100:
- After the next frame_tick, digit 0 shows 0111000 and digit 1 shows 0001000.
- Digit 2 shows 0010010 with sseg[7]=0; digit 3 shows 1001111.
REQ-032 Load ld_hex=16'h0007 with lz_en=1:
- Digits 3..1 show sseg[6:0]=7'h7F while their anodes are still strobed.
- Digit 0 shows 0001111.
- With lz_en=0, digits 3..1 show 0000001.
REQ-033 Issue a second ld_valid while ld_ready=0: it is not accepted.
- Issue a load on the frame_tick cycle: the displayed data changes only after the following frame_tick, 32 cycles later.
REQ-034 Assert rst_n low during digit 2 ON with a load pending:
- On the next cycle an=1111, sseg=8'hFF, ld_ready=1.
- After release, digit 0 shows 0000001.

Source files
------------

// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and constants for the multiplexed seven-segment display
//
// Contents:
//   slot_state_e : per-digit slot phase (blank guard, then lit)
//   SSEG_OFF     : all segments and dp dark (active low)
//   GLYPH_*      : active-low a..g patterns, bit 6 = a, bit 0 = g
//   cnt_width    : counter width helper that never collapses to zero bits
package disp_pkg;

  typedef enum logic [0:0] {
    SLOT_BLANK = 1'b0,
    SLOT_ON    = 1'b1
  } slot_state_e;

  localparam logic [7:0] SSEG_OFF    = 8'hFF;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b1100000;
  localparam logic [6:0] GLYPH_C = 7'b0110001;
  localparam logic [6:0] GLYPH_D = 7'b1000010;
  localparam logic [6:0] GLYPH_E = 7'b0110000;
  localparam logic [6:0] GLYPH_F = 7'b0111000;

  // A limit of 1 would give $clog2 == 0; keep at least one bit.
  function automatic int cnt_width(input int limit);
    return (limit <= 1) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/sseg_decoder.sv
// rtl/sseg_decoder.sv - combinational hex to active-low seven-segment glyph decoder
//
// Ports:
//   hex_i [3:0] : nibble to display
//   seg_o [6:0] : active-low segments, bit 6 = a .. bit 0 = g
module sseg_decoder
  import disp_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = GLYPH_BLANK;
    case (hex_i)
      4'h0: seg_o = GLYPH_0;
      4'h1: seg_o = GLYPH_1;
      4'h2: seg_o = GLYPH_2;
      4'h3: seg_o = GLYPH_3;
      4'h4: seg_o = GLYPH_4;
      4'h5: seg_o = GLYPH_5;
      4'h6: seg_o = GLYPH_6;
      4'h7: seg_o = GLYPH_7;
      4'h8: seg_o = GLYPH_8;
      4'h9: seg_o = GLYPH_9;
      4'hA: seg_o = GLYPH_A;
      4'hB: seg_o = GLYPH_B;
      4'hC: seg_o = GLYPH_C;
      4'hD: seg_o = GLYPH_D;
      4'hE: seg_o = GLYPH_E;
      4'hF: seg_o = GLYPH_F;
      default: seg_o = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_mux_ctrl.sv
// rtl/disp_mux_ctrl.sv - time-multiplexed seven-segment driver with frame-synchronous load
//
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   ld_valid / ld_ready  : load handshake; ld_hex (nibble 0 rightmost) and ld_dp
//                          are captured into a pending buffer on acceptance
//   lz_en                : live leading-zero suppression enable
//   an [N_DIGITS-1:0]    : digit anodes, active low, registered
//   sseg [7:0]           : {dp, a..g}, active low, registered
//   frame_tick           : one-cycle pulse on the last lit cycle of the top digit
module disp_mux_ctrl
  import disp_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int SLOT_CYC  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [4*N_DIGITS-1:0] ld_hex,
  input  logic [N_DIGITS-1:0]   ld_dp,
  input  logic                  lz_en,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            sseg,
  output logic                  frame_tick
);

  localparam int CNT_W = cnt_width(SLOT_CYC);
  localparam int IDX_W = cnt_width(N_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  slot_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;

  logic [4*N_DIGITS-1:0] act_hex_q, act_hex_d;
  logic [N_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*N_DIGITS-1:0] pend_hex_q, pend_hex_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                  pend_full_q, pend_full_d;

  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [7:0]            sseg_q, sseg_d;

  logic                  load_acc;
  logic [N_DIGITS-1:0]   supp;
  logic                  zero_above;
  logic [3:0]            nib_sel;
  logic                  dp_sel;
  logic                  supp_sel;
  logic [6:0]            glyph;

  assign ld_ready   = ~pend_full_q;
  assign load_acc   = ld_valid & ld_ready;
  assign frame_tick = (state_q == SLOT_ON) && (cnt_q == SLOT_LAST) && (idx_q == IDX_LAST);
  assign an         = an_q;
  assign sseg       = sseg_q;

  // cnt_q runs 0..SLOT_CYC-1 across the whole slot; the state only marks
  // which side of the blank guard we are on.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    case (state_q)
      SLOT_BLANK: begin
        if (cnt_q == BLANK_LAST) state_d = SLOT_ON;
      end
      SLOT_ON: begin
        if (cnt_q == SLOT_LAST) begin
          state_d = SLOT_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = SLOT_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // A load that lands on the frame_tick cycle can only happen with the
  // pending buffer empty, so the commit below never sees it this frame.
  always_comb begin
    act_hex_d   = act_hex_q;
    act_dp_d    = act_dp_q;
    pend_hex_d  = pend_hex_q;
    pend_dp_d   = pend_dp_q;
    pend_full_d = pend_full_q;
    if (frame_tick && pend_full_q) begin
      act_hex_d   = pend_hex_q;
      act_dp_d    = pend_dp_q;
      pend_full_d = 1'b0;
    end
    if (load_acc) begin
      pend_hex_d  = ld_hex;
      pend_dp_d   = ld_dp;
      pend_full_d = 1'b1;
    end
  end

  // Walk from the top digit down; a digit is blanked while everything at or
  // above it is zero. Digit 0 always shows.
  always_comb begin
    supp       = '0;
    zero_above = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (act_hex_q[i*4 +: 4] == 4'h0);
      supp[i]    = lz_en & zero_above & (i != 0);
    end
  end

  always_comb begin
    nib_sel  = '0;
    dp_sel   = 1'b0;
    supp_sel = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_sel  = act_hex_q[i*4 +: 4];
        dp_sel   = act_dp_q[i];
        supp_sel = supp[i];
      end
    end
  end

  sseg_decoder u_dec (
    .hex_i (nib_sel),
    .seg_o (glyph)
  );

  always_comb begin
    an_d   = '1;
    sseg_d = SSEG_OFF;
    if (state_q == SLOT_ON) begin
      an_d   = ~(N_DIGITS'(1) << idx_q);
      sseg_d = {~dp_sel, supp_sel ? GLYPH_BLANK : glyph};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SLOT_BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      act_hex_q   <= '0;
      act_dp_q    <= '0;
      pend_hex_q  <= '0;
      pend_dp_q   <= '0;
      pend_full_q <= 1'b0;
      an_q        <= '1;
      sseg_q      <= SSEG_OFF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      act_hex_q   <= act_hex_d;
      act_dp_q    <= act_dp_d;
      pend_hex_q  <= pend_hex_d;
      pend_dp_q   <= pend_dp_d;
      pend_full_q <= pend_full_d;
      an_q        <= an_d;
      sseg_q      <= sseg_d;
    end
  end

endmodule

// File: tb/tb_disp_mux_ctrl.sv
// tb/tb_disp_mux_ctrl.sv - self-checking bench for disp_mux_ctrl
module tb_disp_mux_ctrl;

  localparam int N  = 4;
  localparam int S  = 8;
  localparam int B  = 2;
  localparam int FR = N * S;

  logic        clk = 1'b0;
  logic        rst_n, ld_valid, ld_ready, lz_en, frame_tick;
  logic [15:0] ld_hex;
  logic [3:0]  ld_dp, an;
  logic [7:0]  sseg;

  always #5 clk = ~clk;

  disp_mux_ctrl #(.N_DIGITS(N), .SLOT_CYC(S), .BLANK_CYC(B)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_hex     (ld_hex),
    .ld_dp      (ld_dp),
    .lz_en      (lz_en),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference: p = cycle position inside the frame since reset.
  int          p;
  logic [15:0] m_act_hex, m_pend_hex;
  logic [3:0]  m_act_dp, m_pend_dp;
  bit          m_pv;
  logic [3:0]  e_an;
  logic [7:0]  e_sseg;

  function automatic bit is_frame(input int pp);
    return (pp % S == S - 1) && ((pp / S) % N == N - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_edge();
    int          dg, ph;
    bit          acc, sup;
    logic [15:0] upper;
    if (!rst_n) begin
      p = 0; m_act_hex = 0; m_act_dp = 0; m_pend_hex = 0; m_pend_dp = 0; m_pv = 0;
      e_an = 4'hF; e_sseg = 8'hFF;
    end else begin
      dg = (p / S) % N;
      ph = p % S;
      if (ph < B) begin
        e_an = 4'hF; e_sseg = 8'hFF;
      end else begin
        upper  = m_act_hex >> (4 * dg);
        sup    = lz_en && (dg > 0) && (upper == 16'h0);
        e_an   = 4'hF ^ (4'b0001 << dg);
        e_sseg = {~m_act_dp[dg], sup ? 7'h7F : glyph[upper[3:0]]};
      end
      acc = ld_valid && !m_pv;
      if (is_frame(p) && m_pv) begin
        m_act_hex = m_pend_hex; m_act_dp = m_pend_dp; m_pv = 0;
      end
      if (acc) begin
        m_pend_hex = ld_hex; m_pend_dp = ld_dp; m_pv = 1;
      end
      p = (p + 1) % FR;
    end
  endtask

  task automatic step(input bit rst, input bit v, input logic [15:0] h, input logic [3:0] d, input bit lz);
    rst_n = rst; ld_valid = v; ld_hex = h; ld_dp = d; lz_en = lz;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("an", an, e_an);
    chk("sseg", sseg, e_sseg);
    chk("ld_ready", ld_ready, !m_pv);
    chk("frame_tick", frame_tick, is_frame(p));
  endtask

  task automatic idle(input int n, input bit lz);
    for (int k = 0; k < n; k++) step(1, 0, 16'h0, 4'h0, lz);
  endtask

  task automatic wait_ft(input bit lz);
    bit seen = 0;
    for (int k = 0; k < 2 * FR && !seen; k++) begin
      step(1, 0, 16'h0, 4'h0, lz);
      if (frame_tick) seen = 1;
    end
    if (!seen) chk("frame_timeout", 0, 1);
  endtask

  task automatic spot(input int d, input logic [7:0] exp, input string tag, input bit lz);
    bit found = 0;
    for (int k = 0; k < FR + 4 && !found; k++) begin
      step(1, 0, 16'h0, 4'h0, lz);
      if (an == ~(4'b0001 << d)) found = 1;
    end
    if (!found) chk({tag, "_timeout"}, 0, 1);
    else chk(tag, sseg, exp);
  endtask

  initial begin
    bit lz;
    int ft_cnt;
    step(0, 0, 16'h0, 4'h0, 0);
    step(0, 0, 16'h0, 4'h0, 0);
    chk("rst_an", an, 4'hF);
    chk("rst_sseg", sseg, 8'hFF);
    chk("rst_ready", ld_ready, 1);
    chk("rst_ft", frame_tick, 0);

    // Idle strobing, frame_tick once every 32 cycles.
    ft_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step(1, 0, 16'h0, 4'h0, 0);
      if (frame_tick) ft_cnt++;
    end
    chk("idle_ft_count", ft_cnt, 1);

    // 12AF with dp on digit 2.
    step(1, 1, 16'h12AF, 4'b0100, 0);
    chk("busy_ready", ld_ready, 0);
    wait_ft(0);
    step(1, 0, 16'h0, 4'h0, 0);
    spot(0, {1'b1, 7'b0111000}, "d0_F", 0);
    spot(1, {1'b1, 7'b0001000}, "d1_A", 0);
    spot(2, {1'b0, 7'b0010010}, "d2_2dp", 0);
    spot(3, {1'b1, 7'b1001111}, "d3_1", 0);

    // 0007 with and without leading-zero suppression.
    step(1, 1, 16'h0007, 4'b0000, 1);
    wait_ft(1);
    step(1, 0, 16'h0, 4'h0, 1);
    spot(1, {1'b1, 7'h7F}, "lz_d1", 1);
    spot(2, {1'b1, 7'h7F}, "lz_d2", 1);
    spot(3, {1'b1, 7'h7F}, "lz_d3", 1);
    spot(0, {1'b1, 7'b0001111}, "lz_d0", 1);
    spot(3, {1'b1, 7'b0000001}, "nolz_d3", 0);

    // Second request while busy is ignored; a load on frame_tick waits a frame.
    step(1, 1, 16'h1234, 4'h0, 0);
    step(1, 1, 16'hFFFF, 4'hF, 0);
    step(1, 1, 16'hEEEE, 4'hF, 0);
    chk("busy_ignored", ld_ready, 0);
    wait_ft(0);
    wait_ft(0);
    step(1, 1, 16'h5555, 4'h0, 0);
    spot(0, {1'b1, 7'b1001100}, "ft_load_old", 0);
    wait_ft(0);
    step(1, 0, 16'h0, 4'h0, 0);
    spot(0, {1'b1, 7'b0100100}, "ft_load_new", 0);

    // Random traffic.
    lz = 0;
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(9) == 0) lz = ~lz;
      step(1, ($urandom_range(3) == 0), 16'($urandom), 4'($urandom), lz);
    end

    // Reset during digit 2 lit with a load pending.
    wait_ft(0);
    wait_ft(0);
    step(1, 1, 16'h9876, 4'hF, 0);
    for (int k = 0; k < FR && !((p / S) % N == 2 && p % S > B); k++) idle(1, 0);
    chk("pend_before_rst", ld_ready, 0);
    step(0, 0, 16'h0, 4'h0, 0);
    chk("mid_rst_an", an, 4'hF);
    chk("mid_rst_sseg", sseg, 8'hFF);
    chk("mid_rst_ready", ld_ready, 1);
    spot(0, {1'b1, 7'b0000001}, "post_rst_d0", 0);
    idle(2 * FR, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
